// File: rtl/memory_responder_pkg.sv
// Shared address map and helpers for the nibble memory bus responder.
package memory_responder_pkg;

    localparam logic [11:0] MEM_VRAM0_BASE = 12'hE00;
    localparam logic [11:0] MEM_VRAM1_BASE = 12'hE80;
    localparam logic [11:0] MEM_IO_FACTOR0 = 12'hF00;
    localparam logic [11:0] MEM_IO_FACTOR1 = 12'hF01;
    localparam logic [11:0] MEM_IO_MASK0   = 12'hF10;
    localparam logic [11:0] MEM_IO_MASK1   = 12'hF11;
    localparam logic [11:0] MEM_IO_K0      = 12'hF40;

    localparam int VRAM_BANK_WORDS = 80;
    localparam int VRAM_WORDS      = 2 * VRAM_BANK_WORDS;

    // Which registered source drives the CPU read data.
    typedef enum logic [1:0] {
        SRC_REG,
        SRC_RAM,
        SRC_VRAM
    } rd_src_t;

    // VRAM offsets use bit 7 as the bank select and bits [6:0] as the word in the bank.
    function automatic logic vram_offset_valid(input logic [7:0] offset);
        return offset[6:0] < 7'(VRAM_BANK_WORDS);
    endfunction

    function automatic logic [7:0] vram_index(input logic [7:0] offset);
        return offset[7] ? 8'(offset[6:0]) + 8'(VRAM_BANK_WORDS) : 8'(offset[6:0]);
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// CPU-side nibble memory bus between the register block and the responder.
interface memory_responder_if;
    logic        memory_read_en;
    logic        memory_write_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;

    modport master (
        output memory_read_en, memory_write_en, memory_addr, memory_write_data,
        input  memory_read_data
    );

    modport slave (
        input  memory_read_en, memory_write_en, memory_addr, memory_write_data,
        output memory_read_data
    );
endinterface

// File: rtl/memory_responder_nibble_ram.sv
// Single-clock 4-bit RAM: one read/write port (A) and one read-only port (B).
module nibble_ram #(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [3:0]    a_wdata,
    output logic [3:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [3:0]    b_rdata
);

    logic [3:0] mem [DEPTH];

    // NOTE: the array and its read registers carry no reset, so they map onto RAM
    // primitives; non-blocking assignments make a same-edge read return the old word.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Nibble memory bus responder: main RAM, LCD VRAM, interrupt factor/mask page and k0 input.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int RAM_WORDS = 640
) (
    input  logic                clk,
    input  logic                reset,
    memory_responder_if.slave   bus,
    input  logic [7:0]          irq_factor_set,
    input  logic [3:0]          k0_in,
    input  logic [7:0]          lcd_addr,
    output logic [3:0]          lcd_data,
    output logic                irq_pending
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic              ram_hit;
    logic              vram_hit;
    logic              lcd_hit;
    logic [7:0]        vram_cpu_idx;
    logic [7:0]        vram_lcd_idx;
    logic [3:0]        ram_rdata;
    logic [3:0]        vram_rdata;
    logic [3:0]        vram_lcd_rdata;
    logic [3:0]        ram_b_unused;
    logic [3:0]        io_rdata;
    logic              rd_factor0;
    logic              rd_factor1;

    logic [3:0]        factor0;
    logic [3:0]        factor1;
    logic [3:0]        mask0;
    logic [3:0]        mask1;
    logic [3:0]        k0_meta;
    logic [3:0]        k0_sync;
    logic [3:0]        reg_rdata;
    rd_src_t           rd_src;
    logic              lcd_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ram_hit      = {20'b0, bus.memory_addr} < 32'(RAM_WORDS);
        vram_hit     = (bus.memory_addr[11:8] == MEM_VRAM0_BASE[11:8]) &&
                       vram_offset_valid(bus.memory_addr[7:0]);
        vram_cpu_idx = vram_hit ? vram_index(bus.memory_addr[7:0]) : 8'h00;
        lcd_hit      = vram_offset_valid(lcd_addr);
        vram_lcd_idx = lcd_hit ? vram_index(lcd_addr) : 8'h00;
        rd_factor0   = bus.memory_read_en && (bus.memory_addr == MEM_IO_FACTOR0);
        rd_factor1   = bus.memory_read_en && (bus.memory_addr == MEM_IO_FACTOR1);

        io_rdata = 4'h0;
        case (bus.memory_addr)
            MEM_IO_FACTOR0: io_rdata = factor0;
            MEM_IO_FACTOR1: io_rdata = factor1;
            MEM_IO_MASK0:   io_rdata = mask0;
            MEM_IO_MASK1:   io_rdata = mask1;
            MEM_IO_K0:      io_rdata = k0_sync;
            default:        io_rdata = 4'h0;
        endcase
    end

    // Memory writes are not gated by reset: only register state is cleared.
    nibble_ram #(.DEPTH(RAM_WORDS)) u_ram (
        .clk     (clk),
        .a_en    (bus.memory_read_en && ram_hit),
        .a_we    (bus.memory_write_en && ram_hit),
        .a_addr  (RAM_AW'(bus.memory_addr)),
        .a_wdata (bus.memory_write_data),
        .a_rdata (ram_rdata),
        .b_addr  ('0),
        .b_rdata (ram_b_unused)
    );

    nibble_ram #(.DEPTH(VRAM_WORDS)) u_vram (
        .clk     (clk),
        .a_en    (bus.memory_read_en && vram_hit),
        .a_we    (bus.memory_write_en && vram_hit),
        .a_addr  (vram_cpu_idx),
        .a_wdata (bus.memory_write_data),
        .a_rdata (vram_rdata),
        .b_addr  (vram_lcd_idx),
        .b_rdata (vram_lcd_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            factor0     <= 4'h0;
            factor1     <= 4'h0;
            mask0       <= 4'h0;
            mask1       <= 4'h0;
            k0_meta     <= 4'h0;
            k0_sync     <= 4'h0;
            reg_rdata   <= 4'h0;
            rd_src      <= SRC_REG;
            lcd_valid   <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            k0_meta <= k0_in;
            k0_sync <= k0_meta;

            // A clearing read drops the old bits, but a same-cycle set pulse survives it.
            factor0 <= (rd_factor0 ? 4'h0 : factor0) | irq_factor_set[3:0];
            factor1 <= (rd_factor1 ? 4'h0 : factor1) | irq_factor_set[7:4];

            if (bus.memory_write_en) begin
                if (bus.memory_addr == MEM_IO_MASK0) mask0 <= bus.memory_write_data;
                if (bus.memory_addr == MEM_IO_MASK1) mask1 <= bus.memory_write_data;
            end

            if (bus.memory_read_en) begin
                if (ram_hit) begin
                    rd_src <= SRC_RAM;
                end else if (vram_hit) begin
                    rd_src <= SRC_VRAM;
                end else begin
                    rd_src    <= SRC_REG;
                    reg_rdata <= io_rdata;
                end
            end

            lcd_valid   <= lcd_hit;
            irq_pending <= (|(factor0 & mask0)) || (|(factor1 & mask1));
        end
    end

    always_comb begin
        case (rd_src)
            SRC_RAM:  bus.memory_read_data = ram_rdata;
            SRC_VRAM: bus.memory_read_data = vram_rdata;
            default:  bus.memory_read_data = reg_rdata;
        endcase
        lcd_data = lcd_valid ? vram_lcd_rdata : 4'h0;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed plus randomized bench for memory_responder against an address-level reference model.
module tb_memory_responder;

    localparam int RAM_WORDS = 640;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_factor_set;
    logic [3:0] k0_in;
    logic [7:0] lcd_addr;
    logic [3:0] lcd_data;
    logic       irq_pending;

    memory_responder_if bus();

    memory_responder #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .irq_factor_set (irq_factor_set),
        .k0_in          (k0_in),
        .lcd_addr       (lcd_addr),
        .lcd_data       (lcd_data),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model, keyed by CPU address rather than by physical RAM index.
    logic [3:0] mem_model [int];
    logic [3:0] f0, f1, m0, m1;
    logic [3:0] k0_hist [$];
    logic [3:0] exp_rd, exp_lcd;
    logic       exp_irq;
    bit         rd_known, lcd_known;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit is_ram(input logic [11:0] a);
        return int'(a) < RAM_WORDS;
    endfunction

    function automatic bit is_vram(input logic [11:0] a);
        return (a >= 12'hE00 && a <= 12'hE4F) || (a >= 12'hE80 && a <= 12'hECF);
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [11:0] a;
        logic [11:0] la;
        logic        irq_next;
        a        = bus.memory_addr;
        la       = {4'hE, lcd_addr};
        irq_next = (|(f0 & m0)) || (|(f1 & m1));

        if (reset || !is_vram(la)) begin
            exp_lcd = 4'h0; lcd_known = 1'b1;
        end else if (mem_model.exists(int'(la))) begin
            exp_lcd = mem_model[int'(la)]; lcd_known = 1'b1;
        end else begin
            lcd_known = 1'b0;
        end

        if (reset) begin
            exp_rd = 4'h0; rd_known = 1'b1;
        end else if (bus.memory_read_en) begin
            rd_known = 1'b1;
            if (is_ram(a) || is_vram(a)) begin
                if (mem_model.exists(int'(a))) exp_rd = mem_model[int'(a)];
                else rd_known = 1'b0;
            end else begin
                case (a)
                    12'hF00: exp_rd = f0;
                    12'hF01: exp_rd = f1;
                    12'hF10: exp_rd = m0;
                    12'hF11: exp_rd = m1;
                    12'hF40: exp_rd = k0_hist[0];
                    default: exp_rd = 4'h0;
                endcase
            end
        end

        if (bus.memory_write_en && (is_ram(a) || is_vram(a)))
            mem_model[int'(a)] = bus.memory_write_data;

        if (reset) begin
            f0 = 4'h0; f1 = 4'h0; m0 = 4'h0; m1 = 4'h0;
            k0_hist = {4'h0, 4'h0};
            exp_irq = 1'b0;
        end else begin
            f0 = ((bus.memory_read_en && a == 12'hF00) ? 4'h0 : f0) | irq_factor_set[3:0];
            f1 = ((bus.memory_read_en && a == 12'hF01) ? 4'h0 : f1) | irq_factor_set[7:4];
            if (bus.memory_write_en && a == 12'hF10) m0 = bus.memory_write_data;
            if (bus.memory_write_en && a == 12'hF11) m1 = bus.memory_write_data;
            k0_hist.push_back(k0_in);
            void'(k0_hist.pop_front());
            exp_irq = irq_next;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (rd_known)  check("read_data", bus.memory_read_data, exp_rd);
        if (lcd_known) check("lcd_data", lcd_data, exp_lcd);
        check("irq_pending", {3'b0, irq_pending}, {3'b0, exp_irq});
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
        bus.memory_write_en   = 1'b1;
        bus.memory_addr       = a;
        bus.memory_write_data = d;
        step();
        bus.memory_write_en   = 1'b0;
    endtask

    task automatic cpu_read(input logic [11:0] a);
        bus.memory_read_en = 1'b1;
        bus.memory_addr    = a;
        step();
        bus.memory_read_en = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 12'($urandom_range(0, 15));
            1: return 12'($urandom_range(RAM_WORDS - 4, RAM_WORDS));
            2: return 12'hE4C + 12'($urandom_range(0, 5));
            3: return 12'hECC + 12'($urandom_range(0, 5));
            4: return 12'hE7E + 12'($urandom_range(0, 4));
            5: begin
                case ($urandom_range(0, 6))
                    0: return 12'hF00;
                    1: return 12'hF01;
                    2: return 12'hF10;
                    3: return 12'hF11;
                    4: return 12'hF40;
                    5: return 12'hF02;
                    default: return 12'hF41;
                endcase
            end
            default: return 12'($urandom());
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] k0_reads [3];

        reset                 = 1'b1;
        bus.memory_read_en    = 1'b0;
        bus.memory_write_en   = 1'b0;
        bus.memory_addr       = 12'h000;
        bus.memory_write_data = 4'h0;
        irq_factor_set        = 8'h00;
        k0_in                 = 4'h0;
        lcd_addr              = 8'h00;

        step();
        step();
        check("reset_read_data", bus.memory_read_data, 4'h0);
        check("reset_lcd_data", lcd_data, 4'h0);
        check("reset_irq", {3'b0, irq_pending}, 4'h0);
        reset = 1'b0;

        // RAM write then read, plus unmapped read.
        cpu_write(12'h123, 4'hA);
        cpu_read(12'h123);
        check("ram_read_0x123", bus.memory_read_data, 4'hA);
        cpu_read(12'h300);
        check("unmapped_read_0x300", bus.memory_read_data, 4'h0);

        // VRAM bank 1 through the LCD port, and an out-of-range LCD index.
        cpu_write(12'hE81, 4'h5);
        lcd_addr = 8'h81;
        step();
        check("lcd_0x81", lcd_data, 4'h5);
        lcd_addr = 8'h50;
        step();
        check("lcd_0x50", lcd_data, 4'h0);

        // Masked factor, then unmasking.
        irq_factor_set = 8'h01;
        step();
        irq_factor_set = 8'h00;
        step();
        check("irq_masked", {3'b0, irq_pending}, 4'h0);
        cpu_write(12'hF10, 4'h1);
        step();
        check("irq_unmasked", {3'b0, irq_pending}, 4'h1);

        // Clearing read of factor 0.
        cpu_read(12'hF00);
        check("factor0_read", bus.memory_read_data, 4'h1);
        step();
        check("irq_after_clear", {3'b0, irq_pending}, 4'h0);

        // Set pulse coinciding with a clearing read.
        irq_factor_set = 8'h03;
        step();
        irq_factor_set = 8'h04;
        cpu_read(12'hF00);
        irq_factor_set = 8'h00;
        check("factor0_pre_pulse", bus.memory_read_data, 4'h3);
        cpu_read(12'hF00);
        check("factor0_post_pulse", bus.memory_read_data, 4'h4);

        // Same-address read and write in one cycle returns the old word.
        bus.memory_read_en = 1'b1;
        cpu_write(12'h123, 4'hB);
        bus.memory_read_en = 1'b0;
        check("rw_same_addr_old", bus.memory_read_data, 4'hA);
        cpu_read(12'h123);
        check("rw_same_addr_new", bus.memory_read_data, 4'hB);

        // k0 synchronizer latency.
        k0_in = 4'h9;
        for (int i = 0; i < 3; i++) begin
            cpu_read(12'hF40);
            k0_reads[i] = bus.memory_read_data;
        end
        check("k0_edge1", k0_reads[0], 4'h0);
        check("k0_edge2", k0_reads[1], 4'h0);
        check("k0_edge3", k0_reads[2], 4'h9);

        // Reset mid-sequence: memory write lands, register state clears.
        cpu_write(12'hF11, 4'hF);
        irq_factor_set = 8'hF0;
        step();
        irq_factor_set = 8'h00;
        step();
        check("irq_before_reset", {3'b0, irq_pending}, 4'h1);
        reset = 1'b1;
        cpu_write(12'h010, 4'h7);
        check("reset_mid_irq", {3'b0, irq_pending}, 4'h0);
        check("reset_mid_read_data", bus.memory_read_data, 4'h0);
        reset = 1'b0;
        cpu_read(12'hF11);
        check("mask1_after_reset", bus.memory_read_data, 4'h0);
        cpu_read(12'hF01);
        check("factor1_after_reset", bus.memory_read_data, 4'h0);
        cpu_read(12'h010);
        check("ram_write_during_reset", bus.memory_read_data, 4'h7);
        reset = 1'b1;
        cpu_write(12'hF10, 4'hF);
        reset = 1'b0;
        cpu_read(12'hF10);
        check("mask_write_during_reset", bus.memory_read_data, 4'h0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 800; i++) begin
            bus.memory_read_en    = ($urandom_range(0, 99) < 55);
            bus.memory_write_en   = ($urandom_range(0, 99) < 45);
            bus.memory_addr       = pick_addr();
            bus.memory_write_data = 4'($urandom());
            irq_factor_set        = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
            if ($urandom_range(0, 7) == 0) k0_in = 4'($urandom());
            lcd_addr              = ($urandom_range(0, 1) == 0) ? 8'(pick_addr()) : 8'($urandom());
            reset                 = ($urandom_range(0, 99) == 0);
            step();
        end

        reset               = 1'b0;
        bus.memory_read_en  = 1'b0;
        bus.memory_write_en = 1'b0;
        irq_factor_set      = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Responder end of the CPU core's nibble memory bus. It serves the 12-bit address and 4-bit data read/write requests issued by the register block, decoding them into main RAM, LCD video RAM and a small interrupt I/O page. It also provides a read-only VRAM port for the LCD renderer and drives the interrupt-pending request back to the core.

## Interface
Parameters:
- RAM_WORDS, 640: main RAM depth in nibbles, mapped at 0x000..RAM_WORDS-1.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- memory_read_en  in  1  read request, qualified by memory_addr.
- memory_write_en  in  1  write request, qualified by memory_addr and memory_write_data.
- memory_addr  in  12  nibble address.
- memory_write_data  in  4  write data.
- memory_read_data  out  4  registered read data.
- irq_factor_set  in  8  one-cycle set pulses for the interrupt factor bits; [3:0] go to factor 0, [7:4] go to factor 1.
- k0_in  in  4  asynchronous button inputs.
- lcd_addr  in  8  VRAM index, same encoding as CPU address bits [7:0].
- lcd_data  out  4  registered VRAM data.
- irq_pending  out  1  high while any (factor & mask) bit is set.

## Operation
- Address map (all other addresses are unmapped):
  - 0x000..RAM_WORDS-1: main RAM.
  - 0xE00..0xE4F: VRAM bank 0.
  - 0xE80..0xECF: VRAM bank 1.
  - 0xF00: factor 0.
  - 0xF01: factor 1.
  - 0xF10: mask 0.
  - 0xF11: mask 1.
  - 0xF40: synchronized k0.
- Unmapped reads return 4'h0. Unmapped writes are ignored.
- RAM and VRAM are read/write. Masks are read/write.
- Factor registers ignore CPU writes. Each factor bit is set by its irq_factor_set pulse.
- Reading a factor register returns its current value, then clears it. This clears only when memory_read_en is high.
- k0 register is read-only. It is a 2-flop synchronizer per bit.
- irq_pending = |(factor0 & mask0) | |(factor1 & mask1). It is registered.
- lcd port: lcd_addr in 0x00..0x4F reads bank 0; 0x80..0xCF reads bank 1. Other values return 4'h0.

## Timing
- Read latency is 1 cycle. memory_read_data updates on the edge where memory_read_en is sampled high. It holds its value until the next read.
- Write takes effect on the edge where memory_write_en is high.
- Simultaneous read and write to the same address: the read returns the old data, and the write lands.
- Factor set pulse in the same cycle as a clearing read: the read returns the pre-pulse value, and the pulsed bits remain 1 afterwards. Bits that were not pulsed clear.
- irq_pending is valid 1 cycle after the factor or mask change that causes it.
- k0 has 2 cycles of synchronizer latency into the readable register.
- lcd_data has 1 cycle latency. It is independent of CPU traffic, so there are no stalls on a simultaneous CPU write to the same word: lcd_data returns the old value.
- Reset state:
  - memory_read_data = 0, lcd_data = 0, irq_pending = 0.
  - Factors, masks and synchronizer flops = 0.
  - RAM and VRAM contents are not cleared; they are undefined until written.
- Reset held during a read or write: reset wins. The write to RAM or VRAM still lands, but register writes are dropped.

## Structure
- Address-base and region constants go in the shared `types` package: MEM_VRAM0_BASE, MEM_VRAM1_BASE, MEM_IO_FACTOR0, MEM_IO_FACTOR1, MEM_IO_MASK0, MEM_IO_MASK1, MEM_IO_K0.
- One sub-module, `nibble_ram`: single-clock 4-bit RAM with one write/read port and one read-only port, depth parameterized.
  - Instantiated once for main RAM.
  - Instantiated once for VRAM, with 160 words, bank folded into the index.

## Test plan
- Write 4'hA to 0x123, then read 0x123 → memory_read_data = 4'hA one cycle after the read. Read 0x300 (unmapped) → 4'h0.
- Write 4'h5 to 0xE81 → lcd_addr = 8'h81 gives lcd_data = 4'h5 next cycle. lcd_addr = 8'h50 → 4'h0.
- Pulse irq_factor_set = 8'h01 with mask0 = 0 → irq_pending stays 0. Write mask0 = 4'h1 → irq_pending = 1 one cycle later.
- Read 0xF00 → returns 4'h1, factor0 becomes 0, and irq_pending drops one cycle later.
- Read 0xF00 with factor0 = 4'h3 while irq_factor_set = 8'h04 → returns 4'h3, and factor0 afterwards = 4'h4.
- Set k0_in = 4'h9 → a read of 0xF40 returns 4'h9 only from the third cycle on. Asserting reset mid-sequence → factors, masks and outputs return to 0 on the next edge.
